hex_display_ctrl: RTL and testbench

Parametrised multi-digit seven-segment display controller for the DE1-SoC lab top levels. It latches a DATA_W-bit value from the datapath and drives DIGITS active-low HEX displays. Values wider than the display are shown through a window of DIGITS nibbles, which advances manually (step) or by auto-scroll. Optional blinking and leading-zero blanking are supported. It replaces per-digit decoder instances wired to fixed nibbles.

---
 rtl/hex_display_ctrl_pkg.sv | 34 +++
 rtl/hex_display_ctrl_hex7_decode.sv | 34 +++
 rtl/hex_display_ctrl.sv | 118 +++++++++++
 tb/tb_hex_display_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_display_ctrl_pkg.sv
// Shared definitions for the seven-segment display controller: glyph encodings,
// operating modes and nibble-count helper.
package hex_disp_pkg;

  localparam logic [6:0] GLYPH_0     = 7'b1000000;
  localparam logic [6:0] GLYPH_1     = 7'b1111001;
  localparam logic [6:0] GLYPH_2     = 7'b0100100;
  localparam logic [6:0] GLYPH_3     = 7'b0110000;
  localparam logic [6:0] GLYPH_4     = 7'b0011001;
  localparam logic [6:0] GLYPH_5     = 7'b0010010;
  localparam logic [6:0] GLYPH_6     = 7'b0000010;
  localparam logic [6:0] GLYPH_7     = 7'b1111000;
  localparam logic [6:0] GLYPH_8     = 7'b0000000;
  localparam logic [6:0] GLYPH_9     = 7'b0010000;
  localparam logic [6:0] GLYPH_A     = 7'b0001000;
  localparam logic [6:0] GLYPH_B     = 7'b0000011;
  localparam logic [6:0] GLYPH_C     = 7'b1000110;
  localparam logic [6:0] GLYPH_D     = 7'b0100001;
  localparam logic [6:0] GLYPH_E     = 7'b0000110;
  localparam logic [6:0] GLYPH_F     = 7'b0001110;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  // Encoding 2'b11 is reserved and handled like MODE_STATIC.
  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_SCROLL = 2'b01,
    MODE_BLINK  = 2'b10
  } mode_t;

  function automatic int nib_count(input int width);
    return (width + 3) / 4;
  endfunction

endpackage

// File: rtl/hex_display_ctrl_hex7_decode.sv
// Combinational hex nibble to active-low seven-segment glyph (g..a), with blanking.
module hex7_decode
  import hex_disp_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = GLYPH_BLANK;
    if (!blank) begin
      case (nib)
        4'h0: seg = GLYPH_0;
        4'h1: seg = GLYPH_1;
        4'h2: seg = GLYPH_2;
        4'h3: seg = GLYPH_3;
        4'h4: seg = GLYPH_4;
        4'h5: seg = GLYPH_5;
        4'h6: seg = GLYPH_6;
        4'h7: seg = GLYPH_7;
        4'h8: seg = GLYPH_8;
        4'h9: seg = GLYPH_9;
        4'hA: seg = GLYPH_A;
        4'hB: seg = GLYPH_B;
        4'hC: seg = GLYPH_C;
        4'hD: seg = GLYPH_D;
        4'hE: seg = GLYPH_E;
        4'hF: seg = GLYPH_F;
      endcase
    end
  end

endmodule

// File: rtl/hex_display_ctrl.sv
// Multi-digit seven-segment controller: latched value shown through a window of
// DIGITS nibbles, with manual step, auto-scroll, blink and leading-zero blanking.
module hex_display_ctrl
  import hex_disp_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int DIGITS     = 4,
  parameter int SCROLL_DIV = 50000000,
  parameter int BLINK_DIV  = 25000000,
  localparam int NIB   = nib_count(DATA_W),
  localparam int NWIN  = (NIB + DIGITS - 1) / DIGITS,
  localparam int WIN_W = (NWIN > 1) ? $clog2(NWIN) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_W-1:0]     data_in,
  input  logic                  step,
  input  logic [1:0]            mode,
  input  logic                  lz_blank,
  output logic [7*DIGITS-1:0]   segs,
  output logic [WIN_W-1:0]      win
);

  localparam int PAD_W = NWIN * DIGITS * 4;
  localparam int SC_W  = $clog2(SCROLL_DIV);
  localparam int BL_W  = $clog2(BLINK_DIV);

  logic [DATA_W-1:0]   value;
  logic [PAD_W-1:0]    val_pad;
  logic [SC_W-1:0]     scroll_cnt;
  logic [BL_W-1:0]     blink_cnt;
  logic                blink_on;
  logic                phase_on;
  logic                scroll_tc;
  logic                blink_tc;
  int                  hi;
  logic [7*DIGITS-1:0] glyphs;

  function automatic logic [WIN_W-1:0] next_win(input logic [WIN_W-1:0] w);
    if (w == WIN_W'(NWIN - 1)) return '0;
    return w + WIN_W'(1);
  endfunction

  // Padding to a whole number of windows lets every digit index stay in range.
  assign val_pad = PAD_W'(value);

  always_comb begin
    hi = 0;
    for (int i = 0; i < NIB; i++) begin
      if (val_pad[i*4 +: 4] != 4'h0) hi = i;
    end
  end

  assign scroll_tc = (mode == MODE_SCROLL) && (scroll_cnt == SC_W'(SCROLL_DIV - 1));
  assign blink_tc  = (mode == MODE_BLINK) && (blink_cnt == BL_W'(BLINK_DIV - 1));
  // Leaving BLINK restores the glyphs on the very next edge, not one later.
  assign phase_on  = blink_on || (mode != MODE_BLINK);

  // Stage 0: per-digit nibble select, blanking and decode
  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    int         idx;
    logic [3:0] nib;
    logic       blank;

    always_comb begin
      idx   = int'(win) * DIGITS + d;
      nib   = 4'(val_pad >> (idx * 4));
      blank = (idx >= NIB) || !phase_on || (lz_blank && (idx > hi));
    end

    hex7_decode u_dec (
      .nib   (nib),
      .blank (blank),
      .seg   (glyphs[7*d +: 7])
    );
  end

  // Stage 1: registered display, value, window and timing counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value      <= '0;
      win        <= '0;
      scroll_cnt <= '0;
      blink_cnt  <= '0;
      blink_on   <= 1'b1;
      segs       <= '1;
    end else begin
      segs <= glyphs;
      if (load) value <= data_in;

      case (mode)
        MODE_SCROLL: begin
          scroll_cnt <= scroll_tc ? '0 : scroll_cnt + SC_W'(1);
          if (scroll_tc) win <= next_win(win);
        end
        MODE_BLINK: scroll_cnt <= '0;
        default: begin
          scroll_cnt <= '0;
          if (step) win <= next_win(win);
        end
      endcase

      if (mode == MODE_BLINK) begin
        if (blink_tc) begin
          blink_cnt <= '0;
          blink_on  <= !blink_on;
        end else begin
          blink_cnt <= blink_cnt + BL_W'(1);
        end
      end else begin
        blink_cnt <= '0;
        blink_on  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Bench for hex_display_ctrl: three configurations (single window, two-window 32-bit,
// partial-window 20-bit) checked against an expected-result queue.
module tb_hex_display_ctrl;

  localparam logic [6:0]  BL    = 7'b1111111;
  localparam logic [27:0] ALLBL = 28'hFFFFFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic        a_load, a_step, a_lz;
  logic [1:0]  a_mode;
  logic [15:0] a_data;
  logic [27:0] a_segs;
  logic [0:0]  a_win;

  logic        b_load, b_step, b_lz;
  logic [1:0]  b_mode;
  logic [31:0] b_data;
  logic [27:0] b_segs;
  logic [0:0]  b_win;

  logic        c_load, c_step, c_lz;
  logic [1:0]  c_mode;
  logic [19:0] c_data;
  logic [27:0] c_segs;
  logic [0:0]  c_win;

  hex_display_ctrl #(.DATA_W(16), .DIGITS(4), .SCROLL_DIV(4), .BLINK_DIV(3)) dut_a (
    .clk(clk), .reset(reset), .load(a_load), .data_in(a_data), .step(a_step),
    .mode(a_mode), .lz_blank(a_lz), .segs(a_segs), .win(a_win));

  hex_display_ctrl #(.DATA_W(32), .DIGITS(4), .SCROLL_DIV(4), .BLINK_DIV(3)) dut_b (
    .clk(clk), .reset(reset), .load(b_load), .data_in(b_data), .step(b_step),
    .mode(b_mode), .lz_blank(b_lz), .segs(b_segs), .win(b_win));

  hex_display_ctrl #(.DATA_W(20), .DIGITS(4), .SCROLL_DIV(4), .BLINK_DIV(3)) dut_c (
    .clk(clk), .reset(reset), .load(c_load), .data_in(c_data), .step(c_step),
    .mode(c_mode), .lz_blank(c_lz), .segs(c_segs), .win(c_win));

  typedef struct packed {
    logic [27:0] segs;
    logic        win;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [6:0] gl(input int n);
    case (n)
      0:  return 7'b1000000;
      1:  return 7'b1111001;
      2:  return 7'b0100100;
      3:  return 7'b0110000;
      4:  return 7'b0011001;
      5:  return 7'b0010010;
      6:  return 7'b0000010;
      7:  return 7'b1111000;
      8:  return 7'b0000000;
      9:  return 7'b0010000;
      10: return 7'b0001000;
      11: return 7'b0000011;
      12: return 7'b1000110;
      13: return 7'b0100001;
      14: return 7'b0000110;
      15: return 7'b0001110;
      default: return BL;
    endcase
  endfunction

  function automatic logic [27:0] p4(input logic [6:0] d3, input logic [6:0] d2,
                                     input logic [6:0] d1, input logic [6:0] d0);
    return {d3, d2, d1, d0};
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (a_segs !== ALLBL) begin errors++; $display("FAIL reset a_segs: got %h want %h", a_segs, ALLBL); end
    checks++; if (a_win !== 1'b0) begin errors++; $display("FAIL reset a_win: got %0d want 0", a_win); end
    checks++; if (b_segs !== ALLBL) begin errors++; $display("FAIL reset b_segs: got %h want %h", b_segs, ALLBL); end
    checks++; if (b_win !== 1'b0) begin errors++; $display("FAIL reset b_win: got %0d want 0", b_win); end
    checks++; if (c_segs !== ALLBL) begin errors++; $display("FAIL reset c_segs: got %h want %h", c_segs, ALLBL); end
    reset = 1'b0;
    sb.push_back('{segs: p4(gl(0), gl(0), gl(0), gl(0)), win: 1'b0});
    cyc();
    e = sb.pop_front();
    checks++; if (a_segs !== e.segs) begin errors++; $display("FAIL reset_release a_segs: got %h want %h", a_segs, e.segs); end
    checks++; if (c_segs !== e.segs) begin errors++; $display("FAIL reset_release c_segs: got %h want %h", c_segs, e.segs); end
  endtask

  task automatic test_static_load();
    a_data = 16'h1A3F;
    a_load = 1'b1;
    sb.push_back('{segs: p4(gl(0), gl(0), gl(0), gl(0)), win: 1'b0});
    sb.push_back('{segs: p4(gl(1), gl(10), gl(3), gl(15)), win: 1'b0});
    for (int k = 0; k < 2; k++) begin
      cyc();
      a_load = 1'b0;
      e = sb.pop_front();
      checks++; if (a_segs !== e.segs) begin errors++; $display("FAIL static_load[%0d] segs: got %h want %h", k, a_segs, e.segs); end
      checks++; if (a_win !== e.win) begin errors++; $display("FAIL static_load[%0d] win: got %0d want %0d", k, a_win, e.win); end
    end
  endtask

  task automatic test_lz_blank();
    logic        ld [7];
    logic [15:0] dt [7];
    logic        lz [7];
    logic        st [7];
    logic [27:0] es [7];
    ld[0] = 1; dt[0] = 16'h0042; lz[0] = 1; st[0] = 0; es[0] = p4(gl(1), gl(10), gl(3), gl(15));
    ld[1] = 0; dt[1] = 16'h0000; lz[1] = 1; st[1] = 0; es[1] = p4(BL, BL, gl(4), gl(2));
    ld[2] = 1; dt[2] = 16'h0000; lz[2] = 1; st[2] = 0; es[2] = p4(BL, BL, gl(4), gl(2));
    ld[3] = 0; dt[3] = 16'h0000; lz[3] = 1; st[3] = 0; es[3] = p4(BL, BL, BL, gl(0));
    ld[4] = 1; dt[4] = 16'h0100; lz[4] = 1; st[4] = 0; es[4] = p4(BL, BL, BL, gl(0));
    ld[5] = 0; dt[5] = 16'h0000; lz[5] = 1; st[5] = 0; es[5] = p4(BL, gl(1), gl(0), gl(0));
    ld[6] = 0; dt[6] = 16'h0000; lz[6] = 0; st[6] = 1; es[6] = p4(gl(0), gl(1), gl(0), gl(0));
    for (int k = 0; k < 7; k++) begin
      a_load = ld[k]; a_data = dt[k]; a_lz = lz[k]; a_step = st[k];
      sb.push_back('{segs: es[k], win: 1'b0});
      cyc();
      e = sb.pop_front();
      checks++; if (a_segs !== e.segs) begin errors++; $display("FAIL lz_blank[%0d] segs: got %h want %h", k, a_segs, e.segs); end
      checks++; if (a_win !== e.win) begin errors++; $display("FAIL lz_blank[%0d] win: got %0d want %0d", k, a_win, e.win); end
    end
    a_load = 0; a_step = 0;
  endtask

  task automatic test_scroll();
    logic [27:0] w0, w1;
    w0 = p4(gl(12), gl(13), gl(14), gl(15));
    w1 = p4(gl(8), gl(9), gl(10), gl(11));
    b_data = 32'h89ABCDEF; b_load = 1'b1;
    cyc();
    b_load = 1'b0;
    cyc();
    checks++; if (b_segs !== w0) begin errors++; $display("FAIL scroll_load segs: got %h want %h", b_segs, w0); end
    b_mode = 2'b01; b_step = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      sb.push_back('{segs: ((((k - 1) / 4) % 2) == 1) ? w1 : w0, win: 1'((k / 4) % 2)});
      cyc();
      e = sb.pop_front();
      checks++; if (b_segs !== e.segs) begin errors++; $display("FAIL scroll[%0d] segs: got %h want %h", k, b_segs, e.segs); end
      checks++; if (b_win !== e.win) begin errors++; $display("FAIL scroll[%0d] win: got %0d want %0d", k, b_win, e.win); end
    end
    b_mode = 2'b00; b_step = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sb.push_back('{segs: w1, win: 1'b1});
      cyc();
      e = sb.pop_front();
      checks++; if (b_win !== e.win) begin errors++; $display("FAIL scroll_hold[%0d] win: got %0d want %0d", k, b_win, e.win); end
    end
    b_mode = 2'b01;
    for (int k = 1; k <= 5; k++) begin
      sb.push_back('{segs: (k - 1 >= 4) ? w0 : w1, win: (k >= 4) ? 1'b0 : 1'b1});
      cyc();
      e = sb.pop_front();
      checks++; if (b_segs !== e.segs) begin errors++; $display("FAIL rescroll[%0d] segs: got %h want %h", k, b_segs, e.segs); end
      checks++; if (b_win !== e.win) begin errors++; $display("FAIL rescroll[%0d] win: got %0d want %0d", k, b_win, e.win); end
    end
    b_mode = 2'b11; b_step = 1'b1;
    sb.push_back('{segs: w0, win: 1'b1});
    cyc();
    b_step = 1'b0;
    e = sb.pop_front();
    checks++; if (b_win !== e.win) begin errors++; $display("FAIL reserved_step win: got %0d want %0d", b_win, e.win); end
  endtask

  task automatic test_step();
    logic        ld [9];
    logic [19:0] dt [9];
    logic        lz [9];
    logic        st [9];
    logic [27:0] es [9];
    logic        ew [9];
    c_data = 20'hABCDE; c_load = 1'b1;
    cyc();
    c_load = 1'b0;
    cyc();
    checks++; if (c_segs !== p4(gl(11), gl(12), gl(13), gl(14))) begin errors++; $display("FAIL step_load segs: got %h want %h", c_segs, p4(gl(11), gl(12), gl(13), gl(14))); end
    ld[0] = 0; dt[0] = 20'h0;     lz[0] = 0; st[0] = 1; ew[0] = 1; es[0] = p4(gl(11), gl(12), gl(13), gl(14));
    ld[1] = 0; dt[1] = 20'h0;     lz[1] = 0; st[1] = 0; ew[1] = 1; es[1] = p4(BL, BL, BL, gl(10));
    ld[2] = 1; dt[2] = 20'h12345; lz[2] = 0; st[2] = 1; ew[2] = 0; es[2] = p4(BL, BL, BL, gl(10));
    ld[3] = 0; dt[3] = 20'h0;     lz[3] = 0; st[3] = 0; ew[3] = 0; es[3] = p4(gl(2), gl(3), gl(4), gl(5));
    ld[4] = 1; dt[4] = 20'h00045; lz[4] = 0; st[4] = 1; ew[4] = 1; es[4] = p4(gl(2), gl(3), gl(4), gl(5));
    ld[5] = 0; dt[5] = 20'h0;     lz[5] = 1; st[5] = 0; ew[5] = 1; es[5] = ALLBL;
    ld[6] = 0; dt[6] = 20'h0;     lz[6] = 0; st[6] = 0; ew[6] = 1; es[6] = p4(BL, BL, BL, gl(0));
    ld[7] = 0; dt[7] = 20'h0;     lz[7] = 0; st[7] = 1; ew[7] = 0; es[7] = p4(BL, BL, BL, gl(0));
    ld[8] = 0; dt[8] = 20'h0;     lz[8] = 0; st[8] = 0; ew[8] = 0; es[8] = p4(gl(0), gl(0), gl(4), gl(5));
    for (int k = 0; k < 9; k++) begin
      c_load = ld[k]; c_data = dt[k]; c_lz = lz[k]; c_step = st[k];
      sb.push_back('{segs: es[k], win: ew[k]});
      cyc();
      e = sb.pop_front();
      checks++; if (c_segs !== e.segs) begin errors++; $display("FAIL step[%0d] segs: got %h want %h", k, c_segs, e.segs); end
      checks++; if (c_win !== e.win) begin errors++; $display("FAIL step[%0d] win: got %0d want %0d", k, c_win, e.win); end
    end
    c_load = 0; c_step = 0;
  endtask

  task automatic test_blink();
    logic [27:0] v;
    v = p4(gl(1), gl(10), gl(3), gl(15));
    a_data = 16'h1A3F; a_load = 1'b1; a_lz = 1'b0;
    cyc();
    a_load = 1'b0;
    cyc();
    a_mode = 2'b10;
    for (int k = 1; k <= 5; k++) begin
      sb.push_back('{segs: ((((k - 1) / 3) % 2) == 0) ? v : ALLBL, win: 1'b0});
      cyc();
      e = sb.pop_front();
      checks++; if (a_segs !== e.segs) begin errors++; $display("FAIL blink[%0d] segs: got %h want %h", k, a_segs, e.segs); end
    end
    a_mode = 2'b00;
    sb.push_back('{segs: v, win: 1'b0});
    cyc();
    e = sb.pop_front();
    checks++; if (a_segs !== e.segs) begin errors++; $display("FAIL blink_exit segs: got %h want %h", a_segs, e.segs); end
    a_mode = 2'b10;
    for (int k = 1; k <= 4; k++) begin
      sb.push_back('{segs: ((((k - 1) / 3) % 2) == 0) ? v : ALLBL, win: 1'b0});
      cyc();
      e = sb.pop_front();
      checks++; if (a_segs !== e.segs) begin errors++; $display("FAIL reblink[%0d] segs: got %h want %h", k, a_segs, e.segs); end
    end
    a_mode = 2'b00;
    c_mode = 2'b10; c_step = 1'b1;
    for (int k = 0; k < 2; k++) begin
      sb.push_back('{segs: ALLBL, win: 1'b0});
      cyc();
      c_step = 1'b0;
      e = sb.pop_front();
      checks++; if (c_win !== e.win) begin errors++; $display("FAIL blink_step[%0d] win: got %0d want %0d", k, c_win, e.win); end
    end
    c_mode = 2'b00;
    cyc();
  endtask

  task automatic test_async_reset();
    b_mode = 2'b01;
    cyc();
    cyc();
    #2 reset = 1'b1;
    #1;
    checks++; if (b_segs !== ALLBL) begin errors++; $display("FAIL async_reset b_segs: got %h want %h", b_segs, ALLBL); end
    checks++; if (b_win !== 1'b0) begin errors++; $display("FAIL async_reset b_win: got %0d want 0", b_win); end
    checks++; if (a_segs !== ALLBL) begin errors++; $display("FAIL async_reset a_segs: got %h want %h", a_segs, ALLBL); end
    @(negedge clk);
    reset = 1'b0;
    sb.push_back('{segs: p4(gl(0), gl(0), gl(0), gl(0)), win: 1'b0});
    cyc();
    e = sb.pop_front();
    checks++; if (a_segs[6:0] !== gl(0)) begin errors++; $display("FAIL post_reset a_digit0: got %b want %b", a_segs[6:0], gl(0)); end
    checks++; if (a_segs !== e.segs) begin errors++; $display("FAIL post_reset a_segs: got %h want %h", a_segs, e.segs); end
    checks++; if (b_segs !== e.segs) begin errors++; $display("FAIL post_reset b_segs: got %h want %h", b_segs, e.segs); end
    checks++; if (b_win !== e.win) begin errors++; $display("FAIL post_reset b_win: got %0d want %0d", b_win, e.win); end
  endtask

  initial begin
    reset  = 1'b1;
    a_load = 0; a_step = 0; a_lz = 0; a_mode = 2'b00; a_data = '0;
    b_load = 0; b_step = 0; b_lz = 0; b_mode = 2'b00; b_data = '0;
    c_load = 0; c_step = 0; c_lz = 0; c_mode = 2'b00; c_data = '0;
    test_reset();
    test_static_load();
    test_lz_blank();
    test_scroll();
    test_step();
    test_blink();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
